add_operand_loader: RTL and testbench
=====================================

ADD_OPERAND_LOADER -- requirements
Module: add_operand_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of one input beat.
REQ-002 SHALL have parameter OPERAND_W, default 128, width of each assembled operand; must be a multiple of WORD_W.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  WORD_W  operand word, least-significant word first.
REQ-006 SHALL have port in_cin  input  1  carry-in, sampled only on the final beat of a set.
REQ-007 SHALL have port in_valid  input  1  in_data/in_cin valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts the beat this cycle.
REQ-009 SHALL have ports a, b  output  OPERAND_W  assembled operands, driven straight into the fulladder a/b inputs.
REQ-010 SHALL have port c_in  output  1  assembled carry-in to the fulladder.
REQ-011 SHALL have port out_valid  output  1  a/b/c_in form a complete, stable set.
REQ-012 SHALL have port out_ready  input  1  consumer has taken sum/c_out for the presented set.

Function
REQ-013 SHALL accept a beat only when in_valid && in_ready are both high in the same cycle.
REQ-014 SHALL fill each set with N = OPERAND_W/WORD_W beats into a, then N beats into b, both LSW first.
REQ-015 SHALL capture in_cin into c_in only on beat 2N; in_cin on earlier beats is ignored.
REQ-016 SHALL use FSM states LOAD_A -> LOAD_B -> PRESENT.
  - LOAD_A -> LOAD_B after beat N.
  - LOAD_B -> PRESENT after beat 2N.
  - PRESENT -> LOAD_A when out_ready is high.
REQ-017 SHALL keep a beat counter of width clog2(N), wrapping to 0 on each A->B and B->PRESENT transition.
REQ-018 SHALL assert out_valid exactly in PRESENT; it rises the cycle after the last beat is accepted (latency 1).
REQ-019 SHALL hold a, b and c_in stable while out_valid is high.
REQ-020 SHALL leave a, b and c_in unchanged outside the word currently being written; there is no clearing between sets.
REQ-021 SHALL drive in_ready high in LOAD_A/LOAD_B and low in PRESENT (unless REQ-026).
REQ-022 SHALL allow back-to-back sets: the in_ready high in the cycle after out_ready may accept beat 1 of the next set.
REQ-023 SHALL ignore out_ready outside PRESENT.
REQ-024 SHALL tolerate in_valid gaps at any point without losing or duplicating beats.

Reset
REQ-025 SHALL, on rst_n low (asynchronous, even mid-set), set state to LOAD_A, counter 0, a=0, b=0, c_in=0, out_valid=0, in_ready=0; in_ready rises the first cycle after rst_n deasserts; any partial set is discarded.

Configuration
REQ-026 SHALL, when macro ADD_OPERAND_LOADER_DBLBUF_EN is defined, add a shadow buffer of A, B and cin.
  - in_ready stays high during PRESENT until the shadow holds a full set.
  - On out_ready, a complete shadow transfers to a/b/c_in, and out_valid stays high without a gap cycle.
  - Without the macro, behaviour is exactly REQ-021/REQ-022 with no shadow registers.

Structure
REQ-027 SHALL place the FSM state enum and the WORD_W/OPERAND_W defaults in shared package add_pkg.
REQ-028 SHALL instantiate no sub-module; the fulladder is instantiated alongside this block by the parent, not inside it.

Verification
REQ-029 Bench SHALL cover these scenarios:
  - Reset then 8 beats A=32'h1..4, B=32'h5..8, cin=1 on beat 8 -> out_valid on next cycle; a=128'h00000004_00000003_00000002_00000001, c_in=1; fulladder sum/c_out match a+b+c_in.
  - out_ready held low 20 cycles in PRESENT -> in_ready=0 and a/b/c_in unchanged throughout (non-DBLBUF).
  - Random in_valid gaps over 100 random sets compared against {c_out,sum}=a+b+c_in -> all match, no beat lost.
  - All-ones A, B=1, cin=1 -> sum=128'h1, c_out=1.
  - rst_n pulsed low after beat 5 -> out_valid=0 and a=b=0; a fresh 8-beat set then completes correctly.
  - DBLBUF build: second set streamed during PRESENT, out_ready pulsed -> out_valid stays high and the new set appears the next cycle.

Source files
------------

// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_pkg
// Description : Shared definitions for the adder operand loader: default beat
//               and operand widths, loader FSM state encoding and a helper
//               for sizing the beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

  // Default width of one input beat
  localparam int c_WORD_W_DEFAULT    = 32;
  // Default width of each assembled operand
  localparam int c_OPERAND_W_DEFAULT = 128;

  // Loader FSM: fill A, fill B, then hold the complete set for the adder
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } load_state_t;

  // Beat counter width; a single-beat operand still needs a 1-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : add_operand_loader
// Description : Assembles two wide adder operands (a, b) and a carry-in from
//               a stream of narrow beats, LSW first: N beats into a, then N
//               beats into b, carry taken from the final beat. The complete
//               set is held on a/b/c_in with out_valid until out_ready.
//               Optional macro ADD_OPERAND_LOADER_DBLBUF_EN adds a shadow set
//               so the next operands stream in while the current set is
//               presented, and a full shadow is swapped in with no gap cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module add_operand_loader
  import add_pkg::*;
#(
  parameter int WORD_W    = c_WORD_W_DEFAULT,
  parameter int OPERAND_W = c_OPERAND_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_cin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Beats per operand and the counter that indexes them
  localparam int               N      = OPERAND_W / WORD_W;
  localparam int               CNT_W  = cnt_width(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  // Presented set and loader state
  load_state_t              r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [N-1:0][WORD_W-1:0] r_a;
  logic [N-1:0][WORD_W-1:0] r_b;
  logic                     r_cin;
  logic                     r_out_valid;
  logic                     r_in_ready;

  logic                     w_accept;

  assign w_accept  = in_valid && r_in_ready;

  assign a         = r_a;
  assign b         = r_b;
  assign c_in      = r_cin;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
  // Shadow set, filled only while the main set is being presented. Its fill
  // progress reuses the loader state encoding: PRESENT means "shadow full".
  load_state_t              r_sh_state;
  logic [CNT_W-1:0]         r_sh_cnt;
  logic [N-1:0][WORD_W-1:0] r_sh_a;
  logic [N-1:0][WORD_W-1:0] r_sh_b;
  logic                     r_sh_cin;

  // Shadow contents including any beat accepted this cycle, so a transfer
  // on out_ready never drops the beat arriving alongside it.
  load_state_t              w_sh_state;
  logic [CNT_W-1:0]         w_sh_cnt;
  logic [N-1:0][WORD_W-1:0] w_sh_a;
  logic [N-1:0][WORD_W-1:0] w_sh_b;
  logic                     w_sh_cin;
  logic                     w_sh_accept;
  logic                     w_sh_empty;

  assign w_sh_accept = w_accept && (r_state == PRESENT);
  assign w_sh_empty  = (w_sh_state == LOAD_A) && (w_sh_cnt == '0);

  // Next shadow contents after this cycle's (optional) beat
  always_comb begin
    w_sh_state = r_sh_state;
    w_sh_cnt   = r_sh_cnt;
    w_sh_a     = r_sh_a;
    w_sh_b     = r_sh_b;
    w_sh_cin   = r_sh_cin;
    if (w_sh_accept) begin
      case (r_sh_state)
        LOAD_A: begin
          w_sh_a[r_sh_cnt] = in_data;
          if (r_sh_cnt == C_LAST) begin
            w_sh_cnt   = '0;
            w_sh_state = LOAD_B;
          end else begin
            w_sh_cnt = r_sh_cnt + C_ONE;
          end
        end
        LOAD_B: begin
          w_sh_b[r_sh_cnt] = in_data;
          if (r_sh_cnt == C_LAST) begin
            w_sh_cnt   = '0;
            w_sh_cin   = in_cin;
            w_sh_state = PRESENT;
          end else begin
            w_sh_cnt = r_sh_cnt + C_ONE;
          end
        end
        default: begin
          w_sh_state = r_sh_state;
        end
      endcase
    end
  end
`endif

  // Loader FSM: beat capture, set presentation and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
      r_sh_state  <= LOAD_A;
      r_sh_cnt    <= '0;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_sh_cin    <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD_A: begin
          // First beat after reset release is only enabled here
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a[r_cnt] <= in_data;
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
        end

        LOAD_B: begin
          if (w_accept) begin
            r_b[r_cnt] <= in_data;
            if (r_cnt == C_LAST) begin
              // Last beat: latch carry and present on the next cycle
              r_cnt       <= '0;
              r_cin       <= in_cin;
              r_state     <= PRESENT;
              r_out_valid <= 1'b1;
`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
              r_in_ready  <= 1'b1;
`else
              r_in_ready  <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
        end

        PRESENT: begin
`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
          if (out_ready) begin
            if (w_sh_state == PRESENT) begin
              // Full shadow: swap it in and keep presenting without a gap
              r_a         <= w_sh_a;
              r_b         <= w_sh_b;
              r_cin       <= w_sh_cin;
              r_out_valid <= 1'b1;
            end else begin
              // Partial shadow: hand its progress to the main loader
              if (!w_sh_empty) begin
                r_a <= w_sh_a;
                r_b <= w_sh_b;
              end
              r_state     <= w_sh_state;
              r_cnt       <= w_sh_cnt;
              r_out_valid <= 1'b0;
            end
            r_sh_state <= LOAD_A;
            r_sh_cnt   <= '0;
            r_in_ready <= 1'b1;
          end else begin
            r_sh_state <= w_sh_state;
            r_sh_cnt   <= w_sh_cnt;
            r_sh_a     <= w_sh_a;
            r_sh_b     <= w_sh_b;
            r_sh_cin   <= w_sh_cin;
            r_in_ready <= (w_sh_state != PRESENT);
          end
`else
          // Hold the set until the consumer takes the result
          if (out_ready) begin
            r_state     <= LOAD_A;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
`endif
        end

        default: begin
          r_state     <= LOAD_A;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_operand_loader
// Description : Self-checking bench for add_operand_loader. A driver streams
//               operand sets as LSW-first beats; each completed set is
//               pushed to a scoreboard and a monitor pops and compares it,
//               including the adder result a+b+c_in, on every out_valid &&
//               out_ready handshake. Build with ADD_OPERAND_LOADER_DBLBUF_EN
//               to exercise the shadow-buffer variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_operand_loader;
  import add_pkg::*;

  localparam int WORD_W    = c_WORD_W_DEFAULT;
  localparam int OPERAND_W = c_OPERAND_W_DEFAULT;
  localparam int N         = OPERAND_W / WORD_W;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b1;
  logic [WORD_W-1:0]    in_data   = '0;
  logic                 in_cin    = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic                 c_in;
  logic                 out_valid;
  logic                 out_ready = 1'b0;

  typedef struct {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic                 cin;
  } set_t;

  set_t exp_q[$];
  set_t mon_e;
  int   errors     = 0;
  int   checks     = 0;
  int   ready_mode = 0;  // 0: out_ready low, 1: random, 2: always high

  add_operand_loader #(
    .WORD_W   (WORD_W),
    .OPERAND_W(OPERAND_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_cin   (in_cin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [OPERAND_W:0] act,
                           input logic [OPERAND_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Adder reference: full-width sum of the operands plus carry
  function automatic logic [OPERAND_W:0] add_ref(input logic [OPERAND_W-1:0] x,
                                                 input logic [OPERAND_W-1:0] y,
                                                 input logic ci);
    return {1'b0, x} + {1'b0, y} + {{OPERAND_W{1'b0}}, ci};
  endfunction

  // Monitor: drive out_ready for the coming edge, then score any handshake
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b1;
    endcase
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_set", '1, '0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("set_a", {1'b0, a}, {1'b0, mon_e.a});
        check_val("set_b", {1'b0, b}, {1'b0, mon_e.b});
        check_val("set_cin", {{OPERAND_W{1'b0}}, c_in}, {{OPERAND_W{1'b0}}, mon_e.cin});
        check_val("set_sum", add_ref(a, b, c_in), add_ref(mon_e.a, mon_e.b, mon_e.cin));
      end
    end
  end

  task automatic set_ready_mode(input int m);
    @(negedge clk);
    #1 ready_mode = m;
  endtask

  // One beat, presented at a falling edge; taken on the next rising edge
  task automatic send_beat(input logic [WORD_W-1:0] d, input logic ci, input bit gaps);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_cin   = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = ci;
        if (in_ready) break;
      end
      waited++;
      if (waited > 2000) begin
        check_val("beat_accept_timeout", '0, '1);
        break;
      end
    end
  endtask

  // Whole set: N words of A then N of B, LSW first; carry only on last beat
  task automatic send_set(input logic [OPERAND_W-1:0] av, input logic [OPERAND_W-1:0] bv,
                          input logic ci, input bit gaps);
    set_t                 e;
    logic [OPERAND_W-1:0] src;
    logic                 beat_ci;
    for (int i = 0; i < 2 * N; i++) begin
      src     = (i < N) ? av : bv;
      beat_ci = (i == 2 * N - 1) ? ci : 1'($urandom_range(0, 1));
      send_beat(src[(i % N) * WORD_W +: WORD_W], beat_ci, gaps);
    end
    e.a   = av;
    e.b   = bv;
    e.cin = ci;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d sets pending, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [OPERAND_W-1:0] rand_op();
    logic [OPERAND_W-1:0] v = '0;
    for (int i = 0; i < OPERAND_W / 32; i++) v[i * 32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [OPERAND_W-1:0] a1, b1, a2, b2, ra, rb;
    logic                 exp_rdy;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {{OPERAND_W{1'b0}}, in_ready}, '0);
    check_val("rst_out_valid", {{OPERAND_W{1'b0}}, out_valid}, '0);
    check_val("rst_a", {1'b0, a}, '0);
    check_val("rst_b", {1'b0, b}, '0);
    check_val("rst_cin", {{OPERAND_W{1'b0}}, c_in}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_rst", {{OPERAND_W{1'b0}}, in_ready}, 1);

    // Directed set: A = 1..4, B = 5..8, carry 1
    a1 = 128'h00000004_00000003_00000002_00000001;
    b1 = 128'h00000008_00000007_00000006_00000005;
    send_set(a1, b1, 1'b1, 1'b0);
    check_val("latency_out_valid", {{OPERAND_W{1'b0}}, out_valid}, 1);
    check_val("dir_a", {1'b0, a}, {1'b0, a1});
    check_val("dir_b", {1'b0, b}, {1'b0, b1});
    check_val("dir_cin", {{OPERAND_W{1'b0}}, c_in}, 1);
    check_val("dir_sum", add_ref(a, b, c_in), 129'h0000000c_0000000a_00000008_00000007);
`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    check_val("present_in_ready", {{OPERAND_W{1'b0}}, in_ready}, {{OPERAND_W{1'b0}}, exp_rdy});

`ifdef ADD_OPERAND_LOADER_DBLBUF_EN
    // Stream the next set into the shadow while the first is presented
    a2 = rand_op();
    b2 = rand_op();
    send_set(a2, b2, 1'b0, 1'b0);
    check_val("shadow_full_in_ready", {{OPERAND_W{1'b0}}, in_ready}, '0);
    check_val("shadow_hold_valid", {{OPERAND_W{1'b0}}, out_valid}, 1);
    check_val("shadow_hold_a", {1'b0, a}, {1'b0, a1});
    #1 ready_mode = 2;
    @(negedge clk);
    #1 ready_mode = 0;
    @(negedge clk);
    check_val("swap_out_valid", {{OPERAND_W{1'b0}}, out_valid}, 1);
    check_val("swap_a", {1'b0, a}, {1'b0, a2});
    check_val("swap_b", {1'b0, b}, {1'b0, b2});
    check_val("swap_cin", {{OPERAND_W{1'b0}}, c_in}, '0);
`else
    // Consumer stalls for 20 cycles: set must hold and input stays blocked
    a2 = '0;
    b2 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("stall_in_ready", {{OPERAND_W{1'b0}}, in_ready}, '0);
      check_val("stall_a", {1'b0, a}, {1'b0, a1});
      check_val("stall_b", {1'b0, b}, {1'b0, b1});
      check_val("stall_cin", {{OPERAND_W{1'b0}}, c_in}, 1);
    end
`endif
    #1 ready_mode = 2;
    wait_drain();

    // Random sets with input gaps and a randomly stalling consumer
    set_ready_mode(1);
    for (int s = 0; s < 100; s++) begin
      ra = rand_op();
      rb = rand_op();
      send_set(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    set_ready_mode(2);
    wait_drain();

    // Carry out of the top: all-ones + 1 + 1
    set_ready_mode(0);
    send_set('1, 128'h1, 1'b1, 1'b0);
    check_val("ones_sum", add_ref(a, b, c_in), {1'b1, 128'h1});
    #1 ready_mode = 2;
    wait_drain();

    // Reset in the middle of a set, after beat 5
    set_ready_mode(0);
    ra = rand_op();
    rb = rand_op();
    for (int i = 0; i < 5; i++) begin
      send_beat((i < N) ? ra[i * WORD_W +: WORD_W] : rb[(i - N) * WORD_W +: WORD_W],
                1'b1, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", {{OPERAND_W{1'b0}}, out_valid}, '0);
    check_val("midrst_a", {1'b0, a}, '0);
    check_val("midrst_b", {1'b0, b}, '0);
    check_val("midrst_in_ready", {{OPERAND_W{1'b0}}, in_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_in_ready_rise", {{OPERAND_W{1'b0}}, in_ready}, 1);
    ra = rand_op();
    rb = rand_op();
    send_set(ra, rb, 1'b0, 1'b0);
    check_val("fresh_out_valid", {{OPERAND_W{1'b0}}, out_valid}, 1);
    check_val("fresh_a", {1'b0, a}, {1'b0, ra});
    #1 ready_mode = 2;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
